// File: rtl/qerv_lsu_ctrl.sv
// Load/store sequencer for qerv_bufreg2: operand shift-in, bus transaction,
// load-data shift-out, plus byte-lane selects and per-cycle byte qualifier.
module qerv_lsu_ctrl #(
  parameter int BITS_PER_CYCLE = 4,
  parameter int CYCLES         = 32 / BITS_PER_CYCLE
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_req,
  input  logic       i_we,
  input  logic [1:0] i_size,
  input  logic [1:0] i_lsb,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_misalign,
  output logic       o_init,
  output logic       o_en,
  output logic       o_cnt_done,
  output logic       o_byte_valid,
  output logic       o_load,
  output logic [1:0] o_lsb,
  output logic       o_wb_cyc,
  output logic       o_wb_we,
  output logic [3:0] o_wb_sel,
  input  logic       i_wb_ack
);

  localparam int CW = $clog2(CYCLES);

  typedef enum logic [2:0] {S_IDLE, S_INIT, S_BUS, S_SHIFT, S_DONE} state_t;

  state_t        r_state, w_state_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic          r_we;
  logic [1:0]    r_size;
  logic [1:0]    r_lsb;
  logic          r_misalign;

  logic          w_accept;
  logic          w_misaligned;
  logic          w_last;
  logic [1:0]    w_byte_idx;
  logic          w_shift_valid;
  logic [3:0]    w_sel;

  assign w_accept     = (r_state == S_IDLE) && i_req;
  assign w_misaligned = ((i_size == 2'd1) && i_lsb[0]) || (i_size[1] && (i_lsb != 2'd0));
  assign w_last       = (r_cnt == CW'(CYCLES - 1));

  // Byte of the 32-bit word currently passing through the shift path.
  assign w_byte_idx    = 2'((32'(r_cnt) * BITS_PER_CYCLE) / 8);
  assign w_shift_valid = (w_byte_idx == 2'd0) ||
                         ((w_byte_idx == 2'd1) && (r_size >= 2'd1)) ||
                         (r_size >= 2'd2);

  always_comb begin
    case (r_size)
      2'd0:    w_sel = 4'b0001 << r_lsb;
      2'd1:    w_sel = 4'b0011 << r_lsb;
      default: w_sel = 4'b1111;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_we       <= 1'b0;
      r_size     <= 2'd0;
      r_lsb      <= 2'd0;
      r_misalign <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_misalign <= w_accept && w_misaligned;
      if (w_accept) begin
        r_we   <= i_we;
        r_size <= i_size;
        r_lsb  <= i_lsb;
      end
    end
  end

  // NOTE: every output of this block gets a default first; a missed branch
  // would otherwise infer a latch.
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    o_done       = 1'b0;
    o_init       = 1'b0;
    o_en         = 1'b0;
    o_cnt_done   = 1'b0;
    o_byte_valid = 1'b0;
    o_load       = 1'b0;
    o_wb_cyc     = 1'b0;
    o_wb_we      = 1'b0;
    o_wb_sel     = 4'b0000;
    case (r_state)
      S_IDLE: begin
        if (i_req && !w_misaligned) begin
          w_state_nxt = S_INIT;
          w_cnt_nxt   = '0;
        end
      end
      S_INIT: begin
        o_init       = 1'b1;
        o_en         = 1'b1;
        o_byte_valid = 1'b1;
        w_cnt_nxt    = r_cnt + CW'(1);
        if (w_last) begin
          o_cnt_done  = 1'b1;
          w_state_nxt = S_BUS;
          w_cnt_nxt   = '0;
        end
      end
      S_BUS: begin
        o_wb_cyc = 1'b1;
        o_wb_we  = r_we;
        o_wb_sel = w_sel;
        if (i_wb_ack) begin
          if (r_we) begin
            w_state_nxt = S_DONE;
          end else begin
            o_load      = 1'b1;
            w_state_nxt = S_SHIFT;
            w_cnt_nxt   = '0;
          end
        end
      end
      S_SHIFT: begin
        o_en         = 1'b1;
        o_byte_valid = w_shift_valid;
        w_cnt_nxt    = r_cnt + CW'(1);
        if (w_last) begin
          o_cnt_done  = 1'b1;
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        o_done      = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign o_busy     = (r_state != S_IDLE);
  assign o_misalign = r_misalign;
  assign o_lsb      = r_lsb;

endmodule

// File: tb/tb_qerv_lsu_ctrl.sv
// Self-checking bench for qerv_lsu_ctrl: vector table, hand-written corner
// sequences and random operations against a cycle-timeline reference model.
module tb_qerv_lsu_ctrl;

  localparam int BPC = 4;
  localparam int C   = 32 / BPC;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req, we, ack;
  logic [1:0] size, lsb;
  logic       o_busy, o_done, o_misalign, o_init, o_en, o_cnt_done;
  logic       o_byte_valid, o_load, o_wb_cyc, o_wb_we;
  logic [1:0] o_lsb;
  logic [3:0] o_wb_sel;

  int checks = 0;
  int errors = 0;
  logic [1:0] exp_lsb_q;

  always #5 clk = ~clk;

  qerv_lsu_ctrl #(.BITS_PER_CYCLE(BPC)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_req(req), .i_we(we), .i_size(size), .i_lsb(lsb),
    .o_busy(o_busy), .o_done(o_done), .o_misalign(o_misalign),
    .o_init(o_init), .o_en(o_en), .o_cnt_done(o_cnt_done),
    .o_byte_valid(o_byte_valid), .o_load(o_load), .o_lsb(o_lsb),
    .o_wb_cyc(o_wb_cyc), .o_wb_we(o_wb_we), .o_wb_sel(o_wb_sel),
    .i_wb_ack(ack)
  );

  // Observed outputs, ordered as in ev() below.
  logic [15:0] act_vec;
  assign act_vec = {o_busy, o_done, o_misalign, o_init, o_en, o_cnt_done,
                    o_byte_valid, o_load, o_lsb, o_wb_cyc, o_wb_we, o_wb_sel};

  function automatic logic [15:0] ev(input logic busy, input logic done,
      input logic mis, input logic init, input logic en, input logic cd,
      input logic bv, input logic load, input logic [1:0] l,
      input logic cyc, input logic w, input logic [3:0] sel);
    return {busy, done, mis, init, en, cd, bv, load, l, cyc, w, sel};
  endfunction

  // Reference rules: access width in bytes, lane mask, alignment, byte coverage.
  function automatic int nbytes(input logic [1:0] s);
    return (s == 2'd0) ? 1 : (s == 2'd1) ? 2 : 4;
  endfunction

  function automatic logic [3:0] sel_model(input logic [1:0] s, input logic [1:0] l);
    int m;
    m = ((1 << nbytes(s)) - 1) << l;
    return m[3:0];
  endfunction

  function automatic logic mis_model(input logic [1:0] s, input logic [1:0] l);
    return (int'(l) % nbytes(s)) != 0;
  endfunction

  function automatic logic bv_model(input logic [1:0] s, input int k);
    return ((k * BPC) / 8) < nbytes(s);
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got %b expected %b", name, $time, act, exp);
    end
  endtask

  // Called at a falling edge with inputs already driven; checks this cycle
  // and advances to the next falling edge.
  task automatic cyc_check(input string name, input logic [15:0] exp);
    #1;
    check(name, act_vec, exp);
    @(negedge clk);
  endtask

  task automatic run_op(input logic w, input logic [1:0] s, input logic [1:0] l,
                        input int wait_n, input logic mis, input logic [3:0] sel_e,
                        input bit hold, input bit spur);
    logic a;
    req = 1'b1; we = w; size = s; lsb = l; ack = 1'b0;
    cyc_check("idle_req", ev(0,0,0,0,0,0,0,0,exp_lsb_q,0,0,4'h0));
    exp_lsb_q = l;
    if (hold) begin
      we = ~w; size = ~s; lsb = ~l;
    end else begin
      req = 1'b0;
    end
    if (mis) begin
      cyc_check("misalign_pulse", ev(0,0,1,0,0,0,0,0,l,0,0,4'h0));
      cyc_check("misalign_after", ev(0,0,0,0,0,0,0,0,l,0,0,4'h0));
      return;
    end
    for (int i = 0; i < C; i++) begin
      ack = spur && (i == 2 || i == 3);
      cyc_check("init", ev(1,0,0,1,1,i == C-1,1,0,l,0,0,4'h0));
    end
    for (int j = 0; j <= wait_n; j++) begin
      a = (j == wait_n);
      ack = a;
      cyc_check("bus", ev(1,0,0,0,0,0,0,a && !w,l,1,w,sel_e));
    end
    ack = 1'b0;
    if (!w) begin
      for (int k = 0; k < C; k++)
        cyc_check("shift", ev(1,0,0,0,1,k == C-1,bv_model(s, k),0,l,0,0,4'h0));
    end
    cyc_check("done", ev(1,1,0,0,0,0,0,0,l,0,0,4'h0));
  endtask

  typedef struct {
    logic       we;
    logic [1:0] size;
    logic [1:0] lsb;
    int         wait_n;
    logic       mis;
    logic [3:0] sel;
  } vec_t;

  vec_t tbl[9];

  initial begin
    tbl[0] = '{1'b1, 2'd2, 2'd0, 2, 1'b0, 4'b1111};
    tbl[1] = '{1'b0, 2'd0, 2'd3, 0, 1'b0, 4'b1000};
    tbl[2] = '{1'b0, 2'd1, 2'd2, 1, 1'b0, 4'b1100};
    tbl[3] = '{1'b1, 2'd2, 2'd1, 0, 1'b1, 4'b0000};
    tbl[4] = '{1'b0, 2'd1, 2'd3, 0, 1'b1, 4'b0000};
    tbl[5] = '{1'b1, 2'd0, 2'd2, 0, 1'b0, 4'b0100};
    tbl[6] = '{1'b0, 2'd3, 2'd0, 1, 1'b0, 4'b1111};
    tbl[7] = '{1'b1, 2'd1, 2'd0, 3, 1'b0, 4'b0011};
    tbl[8] = '{1'b0, 2'd3, 2'd2, 0, 1'b1, 4'b0000};

    rst_n = 1'b0; req = 1'b0; we = 1'b0; ack = 1'b0; size = 2'd0; lsb = 2'd0;
    exp_lsb_q = 2'd0;
    #3;
    check("reset_state", act_vec, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    cyc_check("reset_release", 16'h0000);

    foreach (tbl[t])
      run_op(tbl[t].we, tbl[t].size, tbl[t].lsb, tbl[t].wait_n, tbl[t].mis, tbl[t].sel, 1'b0, 1'b0);

    // Misaligned requests back to back in consecutive IDLE cycles.
    req = 1'b1; we = 1'b1; size = 2'd2; lsb = 2'd1;
    cyc_check("mis_b2b_req0", ev(0,0,0,0,0,0,0,0,exp_lsb_q,0,0,4'h0));
    size = 2'd1; lsb = 2'd3;
    cyc_check("mis_b2b_req1", ev(0,0,1,0,0,0,0,0,2'd1,0,0,4'h0));
    req = 1'b0;
    cyc_check("mis_b2b_pulse", ev(0,0,1,0,0,0,0,0,2'd3,0,0,4'h0));
    cyc_check("mis_b2b_after", ev(0,0,0,0,0,0,0,0,2'd3,0,0,4'h0));
    exp_lsb_q = 2'd3;

    // Load with i_req held high and a spurious ack during INIT.
    run_op(1'b0, 2'd1, 2'd2, 1, 1'b0, 4'b1100, 1'b1, 1'b1);
    we = 1'b1; size = 2'd2; lsb = 2'd0; req = 1'b1;
    cyc_check("hold_idle_gap", ev(0,0,0,0,0,0,0,0,2'd2,0,0,4'h0));
    req = 1'b0;
    exp_lsb_q = 2'd0;
    cyc_check("hold_reaccept", ev(1,0,0,1,1,0,1,0,2'd0,0,0,4'h0));
    for (int i = 1; i < C; i++)
      cyc_check("init2", ev(1,0,0,1,1,i == C-1,1,0,2'd0,0,0,4'h0));
    cyc_check("bus_pre_rst0", ev(1,0,0,0,0,0,0,0,2'd0,1,1,4'hf));
    cyc_check("bus_pre_rst1", ev(1,0,0,0,0,0,0,0,2'd0,1,1,4'hf));

    // Asynchronous reset in the middle of BUS.
    we = 1'b0; size = 2'd0; lsb = 2'd3;
    #2 rst_n = 1'b0;
    #1 check("rst_async", act_vec, 16'h0000);
    @(posedge clk);
    #1 check("rst_held", act_vec, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    exp_lsb_q = 2'd0;
    cyc_check("rst_idle", 16'h0000);
    cyc_check("rst_idle2", 16'h0000);
    run_op(1'b0, 2'd0, 2'd3, 0, 1'b0, 4'b1000, 1'b0, 1'b0);

    // Random operations checked against the reference rules.
    for (int r = 0; r < 40; r++) begin
      logic       rw;
      logic [1:0] rs, rl;
      int         rwait;
      rw    = 1'($urandom_range(0, 1));
      rs    = 2'($urandom_range(0, 3));
      rl    = 2'($urandom_range(0, 3));
      rwait = int'($urandom_range(0, 3));
      run_op(rw, rs, rl, rwait, mis_model(rs, rl), sel_model(rs, rl), 1'b0, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/qerv_lsu_ctrl.md
# qerv_lsu_ctrl

Load/store sequencer for the qerv buffer register (`qerv_bufreg2`). It accepts one memory request at a time from decode and drives the buffer register through three phases: init (operand shift-in), the Wishbone-style bus transaction, and load-data shift-out. It also generates the byte-lane selects, the per-cycle byte-valid qualifier and the load strobe. It sits between the decoder, `qerv_bufreg2` and the data bus.

## Interface
Parameters:
- `BITS_PER_CYCLE`, default 4, datapath width per cycle; legal values are 1, 2 and 4.
- `CYCLES`, default `32/BITS_PER_CYCLE`, number of cycles per 32-bit word (derived; do not override).

Ports:
- `i_clk`  in  1  clock; all state updates on its rising edge.
- `i_rst_n`  in  1  asynchronous, active-low reset.
- `i_req`  in  1  start a memory operation; sampled only in IDLE.
- `i_we`  in  1  1 = store, 0 = load; sampled with `i_req`.
- `i_size`  in  2  access size: 0 = byte, 1 = half, 2 = word; 3 is treated as word.
- `i_lsb`  in  2  address bits [1:0]; sampled with `i_req`.
- `o_busy`  out  1  high in every state except IDLE.
- `o_done`  out  1  one-cycle pulse when the operation completes.
- `o_misalign`  out  1  one-cycle pulse when a request is rejected as misaligned.
- `o_init`  out  1  drives bufreg `i_init`.
- `o_en`  out  1  drives bufreg `i_en`.
- `o_cnt_done`  out  1  high on the last cycle of INIT and of SHIFT.
- `o_byte_valid`  out  1  drives bufreg `i_byte_valid`.
- `o_load`  out  1  drives bufreg `i_load`.
- `o_lsb`  out  2  latched `i_lsb`; drives bufreg `i_lsb`.
- `o_wb_cyc`  out  1  bus cycle/strobe.
- `o_wb_we`  out  1  bus write enable.
- `o_wb_sel`  out  4  byte-lane select.
- `i_wb_ack`  in  1  bus acknowledge.

## Operation
- **States:** IDLE, INIT, BUS, SHIFT, DONE. The internal counter `cnt` is `$clog2(CYCLES)` bits wide.
- **IDLE, on `i_req`:**
  - `i_we`, `i_size` and `i_lsb` are latched.
  - The request is misaligned if it is a half access with `lsb[0]=1`, or a word access with `lsb!=0`.
  - Misaligned: `o_misalign` pulses on the next cycle, state stays IDLE, and there is no bus activity.
  - Aligned: go to INIT with `cnt=0`.
- **INIT:**
  - `o_init=1`, `o_en=1`, `o_byte_valid=1`.
  - `cnt` increments each cycle.
  - `o_cnt_done=1` when `cnt==CYCLES-1`; the next state is BUS.
- **BUS:**
  - `o_wb_cyc=1`, `o_wb_we` = latched `we`.
  - `o_wb_sel`: byte → `4'b0001<<lsb`; half → `4'b0011<<lsb`; word → `4'b1111`.
  - On `i_wb_ack`, a store goes to DONE.
  - On `i_wb_ack`, a load asserts `o_load` combinationally in the same cycle (`ack & !we`) and goes to SHIFT with `cnt=0`.
- **SHIFT (loads only):**
  - `o_en=1`.
  - The byte index is `b = (cnt*BITS_PER_CYCLE)/8`.
  - `o_byte_valid = (b==0) | (b==1 & size>=1) | (size>=2)`.
  - `o_cnt_done` is high at `cnt==CYCLES-1`; the next state is DONE.
- **DONE:** `o_done=1` for one cycle, then IDLE.
- **Outside their stated states**, `o_init`, `o_en`, `o_byte_valid`, `o_load`, `o_wb_cyc`, `o_wb_we` and `o_wb_sel` are 0.
- **Ignored inputs:**
  - `i_req` is ignored while busy.
  - `i_wb_ack` is ignored outside BUS.

## Timing
- **Reset:** asserting `i_rst_n` low forces IDLE and `cnt=0` immediately and clears the latched fields. All outputs are 0 during and after reset, including `o_lsb`. A reset mid-operation drops `o_wb_cyc` at once, with no completion pulse.
- **Request accepted at edge n:** INIT covers cycles n+1 … n+CYCLES, and BUS starts at cycle n+CYCLES+1.
- **Ack in cycle m:**
  - Store: `o_done` in cycle m+1.
  - Load: `o_load` in cycle m, SHIFT in cycles m+1 … m+CYCLES, `o_done` in cycle m+CYCLES+1.
- **Zero-wait bus:** an ack in the first BUS cycle is legal. `o_wb_cyc` is high for exactly one cycle.
- **Back-to-back requests:** a new `i_req` is first accepted in the IDLE cycle after DONE, so there is at least one idle cycle between operations.
- **Misalign path:** the `o_misalign` pulse occurs in cycle n+1 and `o_busy` stays 0 throughout.
- **Bus hold:** `o_wb_cyc`, `o_wb_we` and `o_wb_sel` are stable for the whole BUS state.

## Test plan
- **Store, word:** `i_req`, `we=1`, `size=2`, `lsb=0`; ack after 3 BUS cycles → 8 INIT cycles with `o_init=1`; `o_wb_sel=4'b1111` and `o_wb_we=1` for 3 cycles; `o_done` 1 cycle after ack; `o_load` never asserted.
- **Load, byte:** `i_req`, `we=0`, `size=0`, `lsb=3`; zero-wait ack → `o_wb_sel=4'b1000`; `o_load` in the ack cycle; SHIFT for 8 cycles with `o_byte_valid` high only at `cnt` 0–1; `o_done` 9 cycles after ack.
- **Load, half:** `size=1`, `lsb=2` → `o_wb_sel=4'b1100`; `o_byte_valid` high for `cnt` 0–3, low for `cnt` 4–7.
- **Misaligned requests:** word with `lsb=1`, then half with `lsb=3` → each gives a single `o_misalign` pulse; `o_busy`, `o_wb_cyc` and `o_init` stay 0.
- **Ignored inputs:** `i_req` held high throughout a load, plus a spurious `i_wb_ack` during INIT → neither is acted on; exactly one bus cycle; the next operation starts only after DONE → IDLE.
- **Reset mid-operation:** `i_rst_n` pulsed low during BUS while `o_wb_cyc=1` → all outputs drop to 0 asynchronously; IDLE after release; a fresh request completes normally.
